// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session initiator: FSM states, result codes,
// PIN length and the controller-response priority rule.
package atm_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CARD      = 3'd1;
  localparam logic [2:0] S_GAP       = 3'd2;
  localparam logic [2:0] S_DIGIT     = 3'd3;
  localparam logic [2:0] S_SETTLE    = 3'd4;
  localparam logic [2:0] S_AMOUNT    = 3'd5;
  localparam logic [2:0] S_WAIT_RESP = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [2:0] RES_NONE     = 3'd0;
  localparam logic [2:0] RES_DEP_OK   = 3'd1;
  localparam logic [2:0] RES_WDR_OK   = 3'd2;
  localparam logic [2:0] RES_NSF      = 3'd3;
  localparam logic [2:0] RES_PIN_FAIL = 3'd4;
  localparam logic [2:0] RES_BLOCKED  = 3'd5;
  localparam logic [2:0] RES_TIMEOUT  = 3'd6;

  localparam logic [2:0] NUM_DIGITS = 3'd4;

  // Controller flags to result code; RES_NONE means keep waiting.
  function automatic logic [2:0] resp_code(input logic bloqueo, input logic fondos,
                                           input logic entregar, input logic balance,
                                           input logic pin_bad, input logic adv);
    if (bloqueo)                 return RES_BLOCKED;
    else if (fondos)             return RES_NSF;
    else if (entregar && balance) return RES_WDR_OK;
    else if (balance)            return RES_DEP_OK;
    else if (pin_bad || adv)     return RES_PIN_FAIL;
    else                         return RES_NONE;
  endfunction

endpackage

// File: rtl/atm_pin_serializer.sv
// Shifts the latched PIN out MSB-nibble first, one registered strobe per fire,
// and times the idle gap that precedes each strobe.
module atm_pin_serializer #(
  parameter int DIGIT_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] pin,
  input  logic        gap_en,
  input  logic        fire,
  output logic        gap_done,
  output logic        last_digit,
  output logic        digito_stb,
  output logic [3:0]  digito
);
  import atm_pkg::*;

  localparam int GW = $clog2(DIGIT_GAP + 1);

  logic [GW-1:0] gap_cnt;
  logic [15:0]   shreg;
  logic [2:0]    idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_cnt    <= '0;
      shreg      <= '0;
      idx        <= '0;
      digito_stb <= 1'b0;
      digito     <= 4'h0;
    end else begin
      gap_cnt <= gap_en ? gap_cnt + 1'b1 : '0;
      if (load) begin
        shreg <= pin;
        idx   <= '0;
      end else if (fire) begin
        shreg <= {shreg[11:0], 4'h0};
        idx   <= idx + 3'd1;
      end
      digito_stb <= fire;
      digito     <= fire ? shreg[15:12] : 4'h0;
    end
  end

  assign gap_done   = gap_en && (gap_cnt == GW'(DIGIT_GAP - 1));
  assign last_digit = (idx == NUM_DIGITS);

endmodule

// File: rtl/atm_session_initiator.sv
// Initiator side of the ATM controller interface: card pulse, strobed PIN
// digits, strobed amount, then a prioritised result from the response flags.
module atm_session_initiator #(
  parameter int DIGIT_GAP = 2,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pin_in,
  input  logic        trans_type,
  input  logic [31:0] amount,
  input  logic        balance_actualizado,
  input  logic        entregar_dinero,
  input  logic        fondos_insuficientes,
  input  logic        pin_incorrecto,
  input  logic        advertencia,
  input  logic        bloqueo,
  output logic        tarjeta_recibida,
  output logic        tipo_trans,
  output logic        digito_stb,
  output logic [3:0]  digito,
  output logic        monto_stb,
  output logic [31:0] monto,
  output logic        busy,
  output logic        done,
  output logic [2:0]  result
);
  import atm_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);

  logic [2:0]    state, next_state, next_result;
  logic          type_q;
  logic [31:0]   amount_q;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle_cnt;
  logic          accept, gap_done, last_digit;

  assign accept = (state == S_IDLE) && start;

  atm_pin_serializer #(.DIGIT_GAP(DIGIT_GAP)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .pin        (pin_in),
    .gap_en     (state == S_GAP),
    .fire       (next_state == S_DIGIT),
    .gap_done   (gap_done),
    .last_digit (last_digit),
    .digito_stb (digito_stb),
    .digito     (digito)
  );

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    next_state  = state;
    next_result = RES_NONE;
    case (state)
      S_IDLE:   if (start) next_state = S_CARD;
      S_CARD:   next_state = S_GAP;
      S_GAP, S_DIGIT, S_SETTLE: begin
        if (bloqueo) begin
          next_state  = S_DONE;
          next_result = RES_BLOCKED;
        end else if (state == S_GAP) begin
          if (gap_done) next_state = S_DIGIT;
        end else if (state == S_DIGIT) begin
          next_state = last_digit ? S_SETTLE : S_GAP;
        end else if (settle_cnt == SW'(SETTLE - 1)) begin
          next_state = S_AMOUNT;
        end
      end
      S_AMOUNT: next_state = S_WAIT_RESP;
      S_WAIT_RESP: begin
        next_result = resp_code(bloqueo, fondos_insuficientes, entregar_dinero,
                                balance_actualizado, pin_incorrecto, advertencia);
        if (next_result != RES_NONE) begin
          next_state = S_DONE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          next_state  = S_DONE;
          next_result = RES_TIMEOUT;
        end
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      type_q           <= 1'b0;
      amount_q         <= '0;
      timer            <= '0;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      tarjeta_recibida <= 1'b0;
      tipo_trans       <= 1'b0;
      monto_stb        <= 1'b0;
      monto            <= '0;
      done             <= 1'b0;
      result           <= RES_NONE;
    end else begin
      state <= next_state;
      if (accept) begin
        type_q   <= trans_type;
        amount_q <= amount;
      end
      settle_cnt       <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      timer            <= (state == S_WAIT_RESP) ? timer + 1'b1 : '0;
      busy             <= (next_state != S_IDLE);
      tarjeta_recibida <= (next_state == S_CARD);
      tipo_trans       <= (next_state == S_IDLE) ? 1'b0 : (accept ? trans_type : type_q);
      monto_stb        <= (next_state == S_AMOUNT);
      monto            <= (next_state == S_AMOUNT) ? amount_q : '0;
      done             <= (next_state == S_DONE);
      if (accept)
        result <= RES_NONE;
      else if (next_state == S_DONE)
        result <= next_result;
    end
  end

endmodule

// File: tb/tb_atm_session_initiator.sv
// Self-checking bench: each session is turned into an expected per-cycle output
// trace from the protocol timing rules and compared cycle by cycle.
module tb_atm_session_initiator;

  localparam int GAP_P = 2;
  localparam int SET_P = 2;
  localparam int TO_P  = 8;
  localparam int A_CYC = 1 + 4 * (GAP_P + 1) + SET_P;  // cycle of the amount strobe

  localparam int F_BAL = 0, F_ENT = 1, F_NSF = 2, F_PIN = 3, F_ADV = 4, F_BLK = 5;

  typedef struct {
    logic        card;
    logic        tipo;
    logic        stb;
    logic [3:0]  dig;
    logic        mstb;
    logic [31:0] monto;
    logic        busy;
    logic        done;
    logic [2:0]  res;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, start, trans_type;
  logic [15:0] pin_in;
  logic [31:0] amount;
  logic        balance_actualizado, entregar_dinero, fondos_insuficientes;
  logic        pin_incorrecto, advertencia, bloqueo;
  logic        tarjeta_recibida, tipo_trans, digito_stb, monto_stb, busy, done;
  logic [3:0]  digito;
  logic [31:0] monto;
  logic [2:0]  result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  atm_session_initiator #(.DIGIT_GAP(GAP_P), .SETTLE(SET_P), .TIMEOUT(TO_P)) dut (
    .clk(clk), .rst(rst), .start(start), .pin_in(pin_in), .trans_type(trans_type),
    .amount(amount), .balance_actualizado(balance_actualizado),
    .entregar_dinero(entregar_dinero), .fondos_insuficientes(fondos_insuficientes),
    .pin_incorrecto(pin_incorrecto), .advertencia(advertencia), .bloqueo(bloqueo),
    .tarjeta_recibida(tarjeta_recibida), .tipo_trans(tipo_trans), .digito_stb(digito_stb),
    .digito(digito), .monto_stb(monto_stb), .monto(monto), .busy(busy), .done(done),
    .result(result)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [44:0] pack_rec(input rec_t r);
    return {r.card, r.tipo, r.stb, r.dig, r.mstb, r.monto, r.busy, r.done, r.res};
  endfunction

  function automatic string fmt(input logic [44:0] v);
    return $sformatf("card=%b tipo=%b stb=%b dig=%h mstb=%b monto=%h busy=%b done=%b res=%0d",
                     v[44], v[43], v[42], v[41:38], v[37], v[36:5], v[4], v[3], v[2:0]);
  endfunction

  function automatic rec_t idle_rec(input logic [2:0] res);
    rec_t r;
    r.card = 0; r.tipo = 0; r.stb = 0; r.dig = 0; r.mstb = 0;
    r.monto = 0; r.busy = 0; r.done = 0; r.res = res;
    return r;
  endfunction

  // Result priority as seen from the customer side.
  function automatic logic [2:0] model_code(input logic [5:0] f);
    if (f[F_BLK]) return 3'd5;
    if (f[F_NSF]) return 3'd3;
    if (f[F_ENT] && f[F_BAL]) return 3'd2;
    if (f[F_BAL]) return 3'd1;
    if (f[F_PIN] || f[F_ADV]) return 3'd4;
    return 3'd0;
  endfunction

  task automatic drive_flags(input logic [5:0] f);
    balance_actualizado  = f[F_BAL];
    entregar_dinero      = f[F_ENT];
    fondos_insuficientes = f[F_NSF];
    pin_incorrecto       = f[F_PIN];
    advertencia          = f[F_ADV];
    bloqueo              = f[F_BLK];
  endtask

  task automatic check(input string tag, input int c, input rec_t e);
    logic [44:0] obs, ex;
    obs = {tarjeta_recibida, tipo_trans, digito_stb, digito, monto_stb, monto, busy, done, result};
    ex  = pack_rec(e);
    vectors++;
    assert (obs === ex) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: got %s want %s", tag, c, fmt(obs), fmt(ex));
    end
  endtask

  task automatic idle_check(input string tag, input int n, input logic [2:0] res);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check(tag, i, idle_rec(res));
    end
  endtask

  // One session: block_at = cycle with a one-shot bloqueo pulse (-1 none),
  // rst_at = cycle after which reset is asserted (-1 none), lat = response
  // delay after the amount strobe.
  task automatic run_session(input string name, input logic [15:0] pin, input logic t,
                             input logic [31:0] amt, input logic [5:0] fl, input int lat,
                             input int block_at, input int rst_at, output logic [2:0] code_o);
    int d_cyc, n_rec, dn;
    logic [2:0] code;
    logic [5:0] f;
    rec_t r;
    rec_t exp_q[$];

    if (block_at >= 1 && block_at < A_CYC) begin
      d_cyc = block_at + 1;
      code  = 3'd5;
    end else begin
      code = model_code(fl);
      if (code != 3'd0 && lat <= TO_P) d_cyc = A_CYC + lat + 1;
      else begin
        d_cyc = A_CYC + TO_P + 1;
        code  = 3'd6;
      end
    end
    n_rec = (rst_at >= 0 && rst_at < d_cyc) ? rst_at + 2 : d_cyc + 2;

    for (int c = 0; c < n_rec; c++) begin
      if (rst_at >= 0 && c == rst_at + 1) begin
        r = idle_rec(3'd0);
      end else begin
        r = idle_rec((c >= d_cyc) ? code : 3'd0);
        r.busy = (c <= d_cyc);
        r.tipo = (c <= d_cyc) ? t : 1'b0;
        r.card = (c == 0);
        r.done = (c == d_cyc);
        if (c < d_cyc && c >= 1 && c <= 4 * (GAP_P + 1) && (c - 1) % (GAP_P + 1) == GAP_P) begin
          dn    = (c - 1) / (GAP_P + 1);
          r.stb = 1'b1;
          r.dig = 4'(pin >> (4 * (3 - dn)));
        end
        if (c == A_CYC && c < d_cyc) begin
          r.mstb  = 1'b1;
          r.monto = amt;
        end
      end
      exp_q.push_back(r);
    end
    if (n_rec != d_cyc + 2) code = 3'd0;
    code_o = code;

    pin_in = pin; trans_type = t; amount = amt; start = 1'b1;
    for (int c = 0; c < n_rec; c++) begin
      @(posedge clk); #1;
      check(name, c, exp_q[c]);
      // Scramble request inputs and poke start while busy; both must be ignored.
      start      = (c < d_cyc && c < n_rec - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      pin_in     = 16'($urandom);
      trans_type = 1'($urandom);
      amount     = $urandom;
      if (c >= d_cyc || c == n_rec - 1) f = '0;
      else if (c <= A_CYC) begin
        f = 6'($urandom) & 6'h1F;
        f[F_BLK] = (c == block_at);
      end else if (c >= A_CYC + lat) f = fl;
      else f = '0;
      drive_flags(f);
      if (c == rst_at) rst = 1'b0;
      if (c == n_rec - 1) rst = 1'b1;
    end
  endtask

  initial begin
    logic [2:0]  code;
    logic [15:0] p;
    logic [31:0] amt;
    logic [5:0]  fl;
    int          blk;

    rst = 1'b0; start = 1'b0; pin_in = '0; trans_type = 1'b0; amount = '0;
    drive_flags('0);
    idle_check("reset", 3, 3'd0);
    rst = 1'b1;
    idle_check("idle", 2, 3'd0);

    run_session("deposit", 16'h4756, 1'b0, 32'd500, 6'b000001, 3, -1, -1, code);
    idle_check("deposit_idle", 2, code);
    run_session("nsf", 16'h1234, 1'b1, 32'd9000, 6'b000101, 2, -1, -1, code);
    idle_check("nsf_idle", 2, code);
    run_session("wdr_ok", 16'h9081, 1'b1, 32'd1000, 6'b000011, 4, -1, -1, code);
    idle_check("wdr_idle", 2, code);
    run_session("timeout", 16'h5555, 1'b1, 32'd20, 6'b000000, 1, -1, -1, code);
    idle_check("timeout_idle", 2, code);
    run_session("early_block", 16'h2468, 1'b0, 32'd77, 6'b000001, 2, 4, -1, code);
    idle_check("block_idle", 3, code);
    run_session("reset_mid", 16'h1357, 1'b1, 32'd300, 6'b000011, 2, -1, 6, code);
    idle_check("reset_idle", 4, code);
    run_session("fresh", 16'h8642, 1'b0, 32'd250, 6'b000001, 1, -1, -1, code);
    idle_check("fresh_idle", 2, code);

    run_session("amount_zero", 16'h0000, 1'b0, 32'd0, 6'b000001, 1, -1, -1, code);
    run_session("flag_last_cycle", 16'h9999, 1'b1, 32'd42, 6'b001000, TO_P, -1, -1, code);
    run_session("flag_too_late", 16'h3141, 1'b1, 32'd42, 6'b010000, TO_P + 1, -1, -1, code);
    run_session("block_in_card", 16'h2718, 1'b1, 32'd60, 6'b000011, 2, 0, -1, code);
    run_session("block_in_amount", 16'h1618, 1'b0, 32'd61, 6'b010000, 1, A_CYC, -1, code);
    run_session("block_on_strobe", 16'h7777, 1'b0, 32'd62, 6'b000001, 1, 3, -1, code);
    run_session("block_in_settle", 16'h8888, 1'b1, 32'd63, 6'b000001, 1, A_CYC - 1, -1, code);
    run_session("ent_without_bal", 16'h4321, 1'b1, 32'd64, 6'b000010, 1, -1, -1, code);
    run_session("resp_block", 16'h6543, 1'b1, 32'd65, 6'b111111, 2, -1, -1, code);
    idle_check("boundary_idle", 2, code);

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 4; k++) p[4*k +: 4] = 4'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       amt = 32'd0;
        1:       amt = 32'hFFFF_FFFF;
        default: amt = $urandom;
      endcase
      fl  = 6'($urandom);
      blk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, A_CYC)) : -1;
      run_session($sformatf("rand%0d", i), p, 1'($urandom), amt, fl,
                  int'($urandom_range(1, TO_P + 2)), blk, -1, code);
      idle_check($sformatf("rand%0d_idle", i), int'($urandom_range(1, 2)), code);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atm_session_initiator.md
Name: atm_session_initiator

Overview:
Customer-side front-end that drives the ATM controller's input protocol: card-inserted pulse, transaction type, four strobed BCD PIN digits, and a strobed amount. It then collects the controller's response flags and reports a single result code. It sits between the keypad/card-reader logic (or a test sequencer) and the ATM controller, and is the initiator end of that interface.

Parameters:
DIGIT_GAP, 2, idle cycles with digito_stb low before each digit strobe (min 1)
SETTLE, 2, cycles waited after the 4th digit before the amount strobe (min 1)
TIMEOUT, 64, cycles allowed in WAIT_RESP before reporting TIMEOUT (min 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  request a session; sampled only in IDLE
pin_in  in  16  four BCD digits, [15:12] entered first
trans_type  in  1  1 = withdrawal, 0 = deposit
amount  in  32  transaction amount
balance_actualizado  in  1  controller: balance updated
entregar_dinero  in  1  controller: cash dispensed
fondos_insuficientes  in  1  controller: insufficient funds
pin_incorrecto  in  1  controller: wrong PIN
advertencia  in  1  controller: last-attempt warning
bloqueo  in  1  controller: card blocked
tarjeta_recibida  out  1  card-inserted pulse
tipo_trans  out  1  transaction type to controller
digito_stb  out  1  digit strobe
digito  out  4  BCD digit
monto_stb  out  1  amount strobe
monto  out  32  amount to controller
busy  out  1  session in progress
done  out  1  one-cycle session-complete pulse
result  out  3  outcome code, valid from done until next accepted start

Behaviour:
- Clock and reset: reset rst, synchronous, active-low; clock clk. All outputs are registered.
- Reset values: every output is 0, state is IDLE, all counters and latches are 0. A reset mid-session aborts immediately; no partial strobe completes.
- IDLE: busy=0. When start=1, latch pin_in, trans_type and amount, set busy=1, and go to CARD. start is ignored in every other state.
- CARD: tarjeta_recibida=1 for exactly one cycle. tipo_trans is driven with the latched type from CARD through DONE and is 0 in IDLE. Next state is GAP with digit index 0.
- GAP: hold digito_stb=0 for DIGIT_GAP cycles, then go to DIGIT.
- DIGIT: assert digito_stb=1 for one cycle with digito set to the current nibble, sent MSB-first (pin[15:12], [11:8], [7:4], [3:0]). Increment the index. Go to SETTLE when index reaches 4, otherwise back to GAP. digito is 0 whenever digito_stb=0.
- SETTLE: wait SETTLE cycles, then go to AMOUNT.
- AMOUNT: assert monto_stb=1 for one cycle with monto set to the latched amount. monto is 0 otherwise. Amount 0 is legal. Next state is WAIT_RESP with the timer cleared.
- WAIT_RESP: sample the flags each cycle. Result priority is:
  - bloqueo → BLOCKED(5)
  - fondos_insuficientes → NSF(3)
  - entregar_dinero and balance_actualizado → WDR_OK(2)
  - balance_actualizado → DEP_OK(1)
  - pin_incorrecto or advertencia → PIN_FAIL(4)
  - timer reaching TIMEOUT → TIMEOUT(6)
  - The first matching cycle moves to DONE.
- Early block: bloqueo=1 in GAP, DIGIT or SETTLE goes straight to DONE with BLOCKED. No further strobes are issued.
- DONE: done=1 for one cycle and result is registered. busy falls in the following cycle (IDLE). result holds until the next accepted start, which clears it to NONE(0).
- Width rules: timer width is clog2(TIMEOUT+1). The digit index is 3 bits. The amount passes through unmodified, with no arithmetic.
- Session length without early exit: 1 (CARD) + 4·(DIGIT_GAP+1) + SETTLE + 1 (AMOUNT) + response latency.

Decomposition:
- Package atm_pkg holds:
  - state encoding (IDLE, CARD, GAP, DIGIT, SETTLE, AMOUNT, WAIT_RESP, DONE)
  - result codes NONE..TIMEOUT (3-bit)
  - digit count constant 4
- One sub-module is natural: atm_pin_serializer (shift register + gap counter producing digito/digito_stb, with a finished flag).

Test Plan:
1. Deposit: start with pin 0x4756, type 0, amount 500, defaults; assert balance_actualizado 3 cycles after monto_stb → tarjeta pulse, then digits 4,7,5,6 each preceded by 2 low cycles, monto=500 for one cycle, done with result=1.
2. Withdrawal with insufficient funds: type 1, amount 9000; respond fondos_insuficientes and balance_actualizado together → result=3 (priority); tipo_trans=1 throughout the session.
3. Withdrawal OK: amount 1000; respond entregar_dinero with balance_actualizado → result=2, done pulse exactly 1 cycle, busy low the next cycle.
4. Timeout: TIMEOUT=8, no response flags → done exactly 8 cycles after entering WAIT_RESP, result=6.
5. Early block: bloqueo=1 during the second digit's gap → no further digito_stb or monto_stb, result=5.
6. Robustness: start pulsed while busy → ignored; rst=0 after the 2nd digit strobe → all outputs 0 next cycle, no monto_stb; a fresh session then completes normally.
